// File: rtl/configurable_priority_arbiter.sv
// configurable_priority_arbiter
// Registered request arbiter with a valid/ready grant handshake.
// Fixed priority (bit 0 highest) is always available. Defining the macro
// ARB_RR_EN compiles in a round-robin pointer, and rr_mode then picks the
// arbitration mode. Without ARB_RR_EN, rr_mode is accepted but ignored.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no grant presented; arbitrate whenever eligible != 0
// GRANT | grant registers hold a winner; re-arbitrate or drop on accept

module configurable_priority_arbiter #(
    parameter  int NUM_REQ = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] request,
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic               rr_mode,
    input  logic               grant_ready,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_index,
    output logic [NUM_REQ-1:0] grant_onehot
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] eligible;
    logic               lo_found;
    logic [IDX_W-1:0]   lo_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;

    assign eligible = request & req_mask;

    // Lowest-index eligible requester; descending loop leaves the lowest hit.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
    end

`ifdef ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] ptr_after_grant;
    logic [IDX_W-1:0] arb_ptr;
    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;

    // Explicit compare keeps the wrap correct for non-power-of-two NUM_REQ.
    assign ptr_after_grant = (grant_index == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : grant_index + IDX_W'(1);

    // On an accept the new arbitration must already see the advanced pointer,
    // otherwise back-to-back round-robin would re-grant the same requester.
    assign arb_ptr = (grant_valid && grant_ready) ? ptr_after_grant : rr_ptr;

    // Lowest eligible requester at or above the pointer; if none, the search
    // wraps, which is exactly the overall lowest eligible requester.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i] && (i >= int'(arb_ptr))) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(i);
            end
        end
    end

    assign win_idx = (rr_mode && hi_found) ? hi_idx : lo_idx;

    // Pointer advances only on an accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid && grant_ready) begin
            rr_ptr <= ptr_after_grant;
        end
    end
`else
    logic rr_mode_unused;

    assign rr_mode_unused = rr_mode;
    assign win_idx        = lo_idx;
`endif

    assign win_onehot = NUM_REQ'(1) << win_idx;

    // Grant FSM; every output comes straight from these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant_valid  <= 1'b0;
            grant_index  <= '0;
            grant_onehot <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lo_found) begin
                        state        <= GRANT;
                        grant_valid  <= 1'b1;
                        grant_index  <= win_idx;
                        grant_onehot <= win_onehot;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        if (lo_found) begin
                            grant_index  <= win_idx;
                            grant_onehot <= win_onehot;
                        end else begin
                            state        <= IDLE;
                            grant_valid  <= 1'b0;
                            grant_onehot <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_configurable_priority_arbiter.sv
// Bench for configurable_priority_arbiter: an 8-requester and a 5-requester
// instance. Expected grants are queued by the stimulus and popped by a
// monitor whenever a DUT presents grant_valid.

module tb_configurable_priority_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    logic [7:0] req8, mask8, go8;
    logic       mode8, ready8, gv8;
    logic [2:0] gi8;

    logic [4:0] req5, mask5, go5;
    logic       mode5, ready5, gv5;
    logic [2:0] gi5;

    int checks = 0;
    int errors = 0;
    int q8[$];
    int q5[$];

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        int         exp;
    } vec_t;

    vec_t fixed_tbl[6];
    int   rr5_req[4];
    int   rr5_exp[4];

    configurable_priority_arbiter #(.NUM_REQ(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .request      (req8),
        .req_mask     (mask8),
        .rr_mode      (mode8),
        .grant_ready  (ready8),
        .grant_valid  (gv8),
        .grant_index  (gi8),
        .grant_onehot (go8)
    );

    configurable_priority_arbiter #(.NUM_REQ(5)) dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .request      (req5),
        .req_mask     (mask5),
        .rr_mode      (mode5),
        .grant_ready  (ready5),
        .grant_valid  (gv5),
        .grant_index  (gi5),
        .grant_onehot (go5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-requester instance.
    always @(negedge clk) begin
        int e;
        if (rst_n && gv8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8 unexpected grant: index %0d, none expected at %0t", gi8, $time);
            end else begin
                e = q8.pop_front();
                chk("dut8 grant_index", int'(gi8), e);
                chk("dut8 grant_onehot", int'(go8), 1 << e);
            end
        end
    end

    // Monitor for the 5-requester instance.
    always @(negedge clk) begin
        int e;
        if (rst_n && gv5) begin
            if (q5.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut5 unexpected grant: index %0d, none expected at %0t", gi5, $time);
            end else begin
                e = q5.pop_front();
                chk("dut5 grant_index", int'(gi5), e);
                chk("dut5 grant_onehot", int'(go5), 1 << e);
            end
        end
    end

    initial begin
        fixed_tbl[0] = '{8'h80, 8'hFF, 7};
        fixed_tbl[1] = '{8'h30, 8'hFF, 4};
        fixed_tbl[2] = '{8'h28, 8'hFF, 3};
        fixed_tbl[3] = '{8'hFF, 8'hF0, 4};
        fixed_tbl[4] = '{8'hA4, 8'hFF, 2};
        fixed_tbl[5] = '{8'hA4, 8'hFF, 2};

        rr5_req[0] = 5'b10000;  rr5_exp[0] = 4;
        rr5_req[1] = 5'b00001;  rr5_exp[1] = 0;
        rr5_req[2] = 5'b10001;  rr5_exp[2] = RR ? 4 : 0;
        rr5_req[3] = 5'b10001;  rr5_exp[3] = 0;

        rst_n  = 1'b0;
        req8   = '0;  mask8 = 8'hFF; mode8 = 1'b0; ready8 = 1'b1;
        req5   = '0;  mask5 = 5'h1F; mode5 = 1'b0; ready5 = 1'b0;

        // Reset state.
        step();
        step();
        chk("reset grant_valid", int'(gv8), 0);
        chk("reset grant_index", int'(gi8), 0);
        chk("reset grant_onehot", int'(go8), 0);
        chk("reset dut5 grant_valid", int'(gv5), 0);
        rst_n = 1'b1;
        step();
        chk("idle ignores ready", int'(gv8), 0);

        // Fixed priority grant on 1010_0100 held three cycles while request drops.
        ready8 = 1'b0;
        req8   = 8'b1010_0100;
        q8.push_back(2); q8.push_back(2); q8.push_back(2);
        step();
        req8 = '0;
        step();
        step();
        ready8 = 1'b1;
        step();
        chk("drop grant_valid", int'(gv8), 0);
        chk("drop grant_onehot", int'(go8), 0);
        chk("drop keeps grant_index", int'(gi8), 2);
        ready8 = 1'b0;

        // Masked request never wins; unmasking grants one cycle later.
        req8  = 8'h01;
        mask8 = 8'hFE;
        step();
        chk("masked no grant a", int'(gv8), 0);
        step();
        chk("masked no grant b", int'(gv8), 0);
        mask8 = 8'hFF;
        q8.push_back(0);
        step();
        ready8 = 1'b1;
        req8   = '0;
        step();
        chk("unmask then idle", int'(gv8), 0);

        // Back-to-back fixed priority, including re-grant of the accepted requester.
        mode8 = 1'b0;
        foreach (fixed_tbl[i]) begin
            req8  = fixed_tbl[i].req;
            mask8 = fixed_tbl[i].mask;
            q8.push_back(fixed_tbl[i].exp);
            step();
        end
        req8  = '0;
        mask8 = 8'hFF;
        step();
        chk("fixed table then idle", int'(gv8), 0);

        // Round-robin sweep from a freshly reset pointer.
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        mode8  = 1'b1;
        ready8 = 1'b1;
        req8   = 8'hFF;
        for (int i = 0; i < 9; i++) q8.push_back(RR ? (i % 8) : 0);
        for (int i = 0; i < 9; i++) step();
        req8 = '0;
        step();
        chk("rr sweep then idle", int'(gv8), 0);

        // Five requesters: pointer wraps past index 4.
        mode5  = 1'b1;
        ready5 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req5 = 5'(rr5_req[i]);
            q5.push_back(rr5_exp[i]);
            step();
        end
        req5 = '0;
        step();
        chk("dut5 then idle", int'(gv5), 0);

        // Reset during an un-accepted grant clears outputs without a clock edge.
        mode8  = 1'b0;
        ready8 = 1'b0;
        req8   = 8'b1010_0100;
        q8.push_back(2);
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset grant_valid", int'(gv8), 0);
        chk("async reset grant_onehot", int'(go8), 0);
        chk("async reset grant_index", int'(gi8), 0);
        req8 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post reset idle", int'(gv8), 0);
        req8 = 8'h40;
        q8.push_back(6);
        step();
        ready8 = 1'b1;
        req8   = '0;
        step();
        chk("post reset grant then idle", int'(gv8), 0);

        step();
        chk("dut8 expected grants consumed", q8.size(), 0);
        chk("dut5 expected grants consumed", q5.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/configurable_priority_arbiter.md
CONFIGURABLE_PRIORITY_ARBITER -- requirements
Module: configurable_priority_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8, meaning number of requesters, legal range 2..64.
REQ-002 SHALL have localparam IDX_W, default $clog2(NUM_REQ), meaning width of grant_index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port request, input, NUM_REQ bits: per-requester request level.
REQ-006 SHALL have port req_mask, input, NUM_REQ bits: 1 = requester enabled; masked bits never win.
REQ-007 SHALL have port rr_mode, input, 1 bit: 1 = round-robin, 0 = fixed priority, honoured only when ARB_RR_EN is defined.
REQ-008 SHALL have port grant_ready, input, 1 bit: consumer accepts the presented grant.
REQ-009 SHALL have port grant_valid, output, 1 bit: a registered grant is presented.
REQ-010 SHALL have port grant_index, output, IDX_W bits: index of the granted requester.
REQ-011 SHALL have port grant_onehot, output, NUM_REQ bits: one-hot copy of grant_index, all zero when grant_valid = 0.

Function
REQ-012 SHALL define eligible = request & req_mask, evaluated every cycle.
REQ-013 SHALL implement FSM states IDLE and GRANT; the FSM SHALL drive all outputs from registers, with no combinational input-to-output path.
REQ-014 IDLE: if eligible != 0, the block SHALL select a winner, load the grant registers and enter GRANT; grant_valid SHALL rise one cycle after eligible first becomes non-zero. If eligible == 0, the block SHALL remain in IDLE.
REQ-015 Fixed priority SHALL select the lowest-index eligible bit (bit 0 highest).
REQ-016 Round-robin SHALL select the first eligible bit at or above pointer rr_ptr, wrapping past NUM_REQ-1 to 0.
REQ-017 GRANT, grant_ready = 0: grant_index, grant_onehot and grant_valid SHALL hold unchanged, even if the granted request drops or its mask bit clears.
REQ-018 GRANT, grant_ready = 1, eligible != 0: the block SHALL re-arbitrate in the same cycle and present the new grant in the next cycle, with grant_valid remaining 1 (back-to-back, one grant per cycle).
REQ-019 GRANT, grant_ready = 1, eligible == 0: the block SHALL clear grant_valid and grant_onehot, keep grant_index, and enter IDLE.
REQ-020 Arbitration on accept SHALL use eligible in the accept cycle, including the requester just accepted if it is still asserting.
REQ-021 On each accepted grant (grant_valid & grant_ready), rr_ptr SHALL be set to grant_index+1, wrapping to 0 when grant_index = NUM_REQ-1; this SHALL be correct for non-power-of-two NUM_REQ.
REQ-022 rr_ptr SHALL not change when there is no accept.
REQ-023 A change of rr_mode SHALL take effect at the next arbitration only; a held grant SHALL not be affected.
REQ-024 grant_ready while in IDLE SHALL be ignored.

Reset
REQ-025 While rst_n = 0, the block SHALL force: state IDLE, grant_valid 0, grant_index 0, grant_onehot 0, rr_ptr 0.
REQ-026 Reset asserted mid-grant SHALL drop grant_valid immediately, asynchronously.
REQ-027 After reset deasserts, the first arbitration SHALL occur on the first rising edge with eligible != 0.

Configuration
REQ-028 Macro ARB_RR_EN defined: the rr_ptr register and round-robin selection SHALL be compiled in, and rr_mode SHALL select the arbitration mode.
REQ-029 ARB_RR_EN undefined: no rr_ptr logic SHALL exist, rr_mode SHALL be ignored, and the block SHALL always use fixed priority; all ports SHALL remain present.

Verification
REQ-030 Bench SHALL cover: NUM_REQ=8, fixed, mask=FF, request=8'b1010_0100 in IDLE -> next cycle grant_valid=1, grant_index=2, grant_onehot=8'h04.
REQ-031 Bench SHALL cover: grant on idx 2 with grant_ready=0 for 3 cycles while request drops to 0 -> idx 2 held all 3 cycles; then ready=1 -> grant_valid=0 next cycle.
REQ-032 Bench SHALL cover: ARB_RR_EN, rr_mode=1, request=FF held, grant_ready=1 continuously -> grant_index sequence 0,1,...,7,0, one per cycle.
REQ-033 Bench SHALL cover: NUM_REQ=5, ARB_RR_EN, rr_mode=1, accept idx 4, request=5'b00001 -> rr_ptr wraps to 0, next grant_index=0.
REQ-034 Bench SHALL cover: request=8'h01, req_mask=8'hFE -> grant_valid stays 0; mask changed to FF -> grant idx 0 one cycle later.
REQ-035 Bench SHALL cover: rst_n pulled low during an un-accepted grant -> grant_valid=0, grant_onehot=0 without waiting for a clock edge; ARB_RR_EN undefined with rr_mode=1 -> fixed priority result.
